motor_drive: RTL and testbench

MOTOR_DRIVE -- requirements
Module: motor_drive

---
 rtl/motor_drive_pkg.sv | 33 +++
 rtl/motor_drive_duty_ramp.sv | 53 +++++
 rtl/motor_drive.sv | 92 +++++++++
 tb/tb_motor_drive.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/motor_drive_pkg.sv
// Shared mode encoding and default drive constants for the motor and sensor-tracking blocks.
package motor_drive_pkg;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    STRI = 2'd1,
    RT   = 2'd2,
    LT   = 2'd3
  } mode_e;

  localparam int DUTY_W            = 10;
  localparam int PWM_PERIOD_DEF    = 1000;
  localparam int DUTY_FULL_DEF     = 800;
  localparam int DUTY_TURN_DEF     = 300;
  localparam int RAMP_STEP_DEF     = 50;
  localparam int DWELL_PERIODS_DEF = 4;

  // Per-mode wheel targets, packed as {left, right}.
  function automatic logic [2*DUTY_W-1:0] mode_targets(input mode_e m,
                                                       input logic [DUTY_W-1:0] full,
                                                       input logic [DUTY_W-1:0] turn);
    logic [2*DUTY_W-1:0] t;
    t = '0;
    case (m)
      STRI:    t = {full, full};
      RT:      t = {full, turn};
      LT:      t = {turn, full};
      default: t = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/motor_drive_duty_ramp.sv
// Per-wheel duty ramp and PWM comparator; duty only moves at a period wrap or on stop.
module duty_ramp
  import motor_drive_pkg::*;
#(
  parameter int RAMP_STEP = RAMP_STEP_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DUTY_W-1:0] pwm_cnt,
  input  logic              wrap,
  input  logic [DUTY_W-1:0] target,
  input  logic              stop,
  output logic [DUTY_W-1:0] duty,
  output logic              motor
);

  localparam logic [DUTY_W:0]   STEP_W = (DUTY_W+1)'(RAMP_STEP);
  localparam logic [DUTY_W-1:0] STEP_N = DUTY_W'(RAMP_STEP);

  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              motor_q, motor_d;
  logic [DUTY_W:0]   gap;

  // Next duty: forced to zero on stop, otherwise a bounded step toward target at wrap.
  always_comb begin
    duty_d  = duty_q;
    motor_d = ~stop & (pwm_cnt < duty_q);
    gap     = (target >= duty_q) ? ({1'b0, target} - {1'b0, duty_q})
                                 : ({1'b0, duty_q} - {1'b0, target});
    if (stop) begin
      duty_d = '0;
    end else if (wrap) begin
      if (gap <= STEP_W)        duty_d = target;
      else if (target > duty_q) duty_d = duty_q + STEP_N;
      else                      duty_d = duty_q - STEP_N;
    end
  end

  // Duty and PWM output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_q  <= '0;
      motor_q <= 1'b0;
    end else begin
      duty_q  <= duty_d;
      motor_q <= motor_d;
    end
  end

  assign duty  = duty_q;
  assign motor = motor_q;

endmodule

// File: rtl/motor_drive.sv
// Two-wheel drive: request register, dwell-limited mode selection, PWM counter, per-wheel ramps.
module motor_drive
  import motor_drive_pkg::*;
#(
  parameter int PWM_PERIOD    = PWM_PERIOD_DEF,
  parameter int DUTY_FULL     = DUTY_FULL_DEF,
  parameter int DUTY_TURN     = DUTY_TURN_DEF,
  parameter int RAMP_STEP     = RAMP_STEP_DEF,
  parameter int DWELL_PERIODS = DWELL_PERIODS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        state,
  output logic              left_motor,
  output logic              right_motor,
  output logic [1:0]        mode,
  output logic [DUTY_W-1:0] left_duty,
  output logic [DUTY_W-1:0] right_duty
);

  localparam int              DWELL_W = 8;
  localparam logic [DUTY_W-1:0] WRAP_AT = DUTY_W'(PWM_PERIOD - 1);

  mode_e               state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [DUTY_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic                wrap, stop;
  logic [2*DUTY_W-1:0] tgt;

  assign wrap = (pwm_cnt_q == WRAP_AT);
  assign stop = (mode_q == STOP);
  assign tgt  = mode_targets(mode_q, DUTY_W'(DUTY_FULL), DUTY_W'(DUTY_TURN));

  // Free-running PWM period counter.
  always_comb begin
    pwm_cnt_d = wrap ? '0 : pwm_cnt_q + 1'b1;
  end

  // Mode follows the latest request when STOP or the dwell has expired; dwell reloads on entry.
  always_comb begin
    state_d = mode_e'(state);
    mode_d  = mode_q;
    dwell_d = dwell_q;
    if (state_q == STOP || dwell_q == '0) mode_d = state_q;
    if (mode_d != mode_q) begin
      dwell_d = (mode_d == STOP) ? '0 : DWELL_W'(DWELL_PERIODS);
    end else if (wrap && dwell_q != '0) begin
      dwell_d = dwell_q - 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= STOP;
      mode_q    <= STOP;
      dwell_q   <= '0;
      pwm_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      dwell_q   <= dwell_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  duty_ramp #(.RAMP_STEP(RAMP_STEP)) u_left (
    .clk     (clk),
    .reset   (reset),
    .pwm_cnt (pwm_cnt_q),
    .wrap    (wrap),
    .target  (tgt[2*DUTY_W-1:DUTY_W]),
    .stop    (stop),
    .duty    (left_duty),
    .motor   (left_motor)
  );

  duty_ramp #(.RAMP_STEP(RAMP_STEP)) u_right (
    .clk     (clk),
    .reset   (reset),
    .pwm_cnt (pwm_cnt_q),
    .wrap    (wrap),
    .target  (tgt[DUTY_W-1:0]),
    .stop    (stop),
    .duty    (right_duty),
    .motor   (right_motor)
  );

  assign mode = mode_q;

endmodule

// File: tb/tb_motor_drive.sv
// Bench for motor_drive: cycle model of the drive rules plus directed ramp/turn/dwell/stop/reset checks.
module tb_motor_drive;

  localparam int P     = 1000;
  localparam int FULL  = 800;
  localparam int TURN  = 300;
  localparam int STEP  = 50;
  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state;
  logic       left_motor, right_motor;
  logic [1:0] mode;
  logic [9:0] left_duty, right_duty;
  logic       b_lm, b_rm;
  logic [1:0] b_mode;
  logic [9:0] b_ld, b_rd;

  int ncomp = 0;
  int nfail = 0;

  motor_drive dut (
    .clk(clk), .reset(reset), .state(state),
    .left_motor(left_motor), .right_motor(right_motor), .mode(mode),
    .left_duty(left_duty), .right_duty(right_duty)
  );

  // Boundary instance: full duty equals the period, and one ramp step covers everything.
  motor_drive #(.DUTY_FULL(1000), .RAMP_STEP(1000)) dut_b (
    .clk(clk), .reset(reset), .state(state),
    .left_motor(b_lm), .right_motor(b_rm), .mode(b_mode),
    .left_duty(b_ld), .right_duty(b_rd)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_sq, m_mode, m_dwell, m_cnt, m_ld, m_rd, m_lm, m_rm, wraps;

  function automatic int tgt_l(int m);
    return (m == 0) ? 0 : (m == 3) ? TURN : FULL;
  endfunction
  function automatic int tgt_r(int m);
    return (m == 0) ? 0 : (m == 2) ? TURN : FULL;
  endfunction
  function automatic int ramp(int d, int t);
    if (t > d) return (d + STEP > t) ? t : d + STEP;
    else       return (d - STEP < t) ? t : d - STEP;
  endfunction

  task automatic m_reset();
    m_sq = 0; m_mode = 0; m_dwell = 0; m_cnt = 0;
    m_ld = 0; m_rd = 0; m_lm = 0; m_rm = 0;
  endtask

  task automatic m_edge();
    int w, nm, nd, nl, nr;
    w  = (m_cnt == P - 1);
    nm = (m_sq == 0 || m_dwell == 0) ? m_sq : m_mode;
    if (nm != m_mode)         nd = (nm == 0) ? 0 : DWELL;
    else if (w && m_dwell > 0) nd = m_dwell - 1;
    else                       nd = m_dwell;
    nl = (m_mode == 0) ? 0 : w ? ramp(m_ld, tgt_l(m_mode)) : m_ld;
    nr = (m_mode == 0) ? 0 : w ? ramp(m_rd, tgt_r(m_mode)) : m_rd;
    m_lm  = (m_mode != 0 && m_cnt < m_ld) ? 1 : 0;
    m_rm  = (m_mode != 0 && m_cnt < m_rd) ? 1 : 0;
    m_cnt = w ? 0 : m_cnt + 1;
    m_ld = nl; m_rd = nr; m_mode = nm; m_dwell = nd;
    m_sq = int'(state);
    wraps += w;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: advance model on the edge, then compare just after it.
  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
    chk("motors", {30'd0, left_motor, right_motor}, 32'(m_lm * 2 + m_rm));
    chk("mode",   {30'd0, mode},                    32'(m_mode));
    chk("duties", {12'd0, left_duty, right_duty},   32'(m_ld * 1024 + m_rd));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_wrap();
    int w0;
    w0 = wraps;
    for (int i = 0; i < P + 2 && wraps == w0; i++) step();
  endtask

  initial begin
    int cnt_l, cnt_b, w0;
    wraps = 0;
    m_reset();
    reset = 1'b0;
    state = 2'd0;
    #1;
    chk("rst_motors", {30'd0, left_motor, right_motor}, 0);
    chk("rst_mode",   {30'd0, mode}, 0);
    chk("rst_duties", {12'd0, left_duty, right_duty}, 0);
    state = 2'd1;
    #1 reset = 1'b1;

    // Ramp-up: 50 per wrap to 800; boundary instance jumps straight to 1000.
    for (int k = 1; k <= 16; k++) begin
      run(P);
      chk("ramp_left", {22'd0, left_duty}, 32'(50 * k));
      if (k == 1) chk("bnd_jump", {22'd0, b_ld}, 1000);
    end
    cnt_l = 0; cnt_b = 0;
    for (int i = 0; i < P; i++) begin
      step();
      cnt_l += int'(left_motor);
      cnt_b += int'(b_lm);
    end
    chk("left_high_cnt", 32'(cnt_l), 800);
    chk("bnd_const_one", 32'(cnt_b), 1000);

    // Turning: mode follows two cycles later, right steps down to 300.
    state = 2'd2;
    step(); chk("rt_lat1", {30'd0, mode}, 1);
    step(); chk("rt_lat2", {30'd0, mode}, 2);
    for (int k = 1; k <= 10; k++) begin
      run_until_wrap();
      chk("turn_right", {22'd0, right_duty}, 32'(800 - 50 * k));
      chk("turn_left",  {22'd0, left_duty}, 800);
    end

    // Back to straight and ramp right wheel up again.
    state = 2'd1;
    run(2);
    chk("stri_back", {30'd0, mode}, 1);
    for (int k = 0; k < 10; k++) run_until_wrap();
    chk("stri_right", {22'd0, right_duty}, 800);

    // Dwell: LT requested one period into RT is held off until 4 wraps after entry.
    state = 2'd2;
    run(2);
    chk("dw_rt", {30'd0, mode}, 2);
    w0 = wraps;
    run(P);
    state = 2'd3;
    for (int i = 0; i < 5 * P && wraps < w0 + 4; i++) step();
    chk("dw_hold", {30'd0, mode}, 2);
    step();
    chk("dw_lt", {30'd0, mode}, 3);

    // STOP on the pwm_cnt==999 cycle, mid-dwell and mid-ramp.
    for (int i = 0; i < P && m_cnt != P - 1; i++) step();
    state = 2'd0;
    run(2);
    chk("stop_mode", {30'd0, mode}, 0);
    step();
    chk("stop_motors", {30'd0, left_motor, right_motor}, 0);
    chk("stop_duties", {12'd0, left_duty, right_duty}, 0);

    // Asynchronous reset mid-period, then ramp restarts from zero.
    state = 2'd1;
    run(2500);
    #3 reset = 1'b0;
    m_reset();
    #1;
    chk("arst_motors", {30'd0, left_motor, right_motor}, 0);
    chk("arst_mode",   {30'd0, mode}, 0);
    chk("arst_duties", {12'd0, left_duty, right_duty}, 0);
    #2 reset = 1'b1;
    run(P);
    chk("arst_ramp", {22'd0, left_duty}, 50);
    chk("arst_bnd",  {22'd0, b_ld}, 1000);

    // Randomized request sequences against the model.
    for (int s = 0; s < 20; s++) begin
      state = 2'($urandom_range(0, 3));
      run($urandom_range(1, 1200));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
